// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    // One complete display image: four nibbles plus per-digit dp and blank flags.
    typedef struct packed {
        logic [NUM_DIGITS*DIGIT_W-1:0] value;
        logic [NUM_DIGITS-1:0]         dp;
        logic [NUM_DIGITS-1:0]         blank;
    } disp_t;

    localparam disp_t DISP_RESET = '0;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Lower-case b and d keep them distinct from 8 and 0.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_HEX_0;
        unique case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            4'hF: seg_o = SEG_HEX_F;
            default: seg_o = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan engine with a frame-synchronous double-buffered display image.
// en, seg and dp are registered together so the shown digit and its pattern never disagree.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    localparam int unsigned CNT_W      = $clog2(REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic [1:0]  en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] en_q, en_d;
    disp_t            active_q, active_d;
    disp_t            pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic  tick;
    logic  boundary;
    disp_t incoming;
    logic [DIGIT_W-1:0] next_nibble;
    logic [6:0]         next_glyph;

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (en_q == IDX_LAST);
    assign incoming = '{value: value_in, dp: dp_in, blank: blank_in};

    always_comb begin
        cnt_d           = tick ? '0 : cnt_q + 1'b1;
        en_d            = tick ? en_q + 1'b1 : en_q;
        frame_done_d    = boundary;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;

        if (boundary) begin
            // A load coincident with the boundary bypasses the pending buffer.
            if (load) begin
                active_d = incoming;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = incoming;
            pending_valid_d = 1'b1;
        end
    end

    // Outputs are built from the post-commit image and next index so they land with en.
    assign next_nibble = active_d.value[{en_d, 2'b00} +: DIGIT_W];

    hex_to_seg u_hex_to_seg (
        .nibble_i (next_nibble),
        .seg_o    (next_glyph)
    );

    always_comb begin
        seg_d = next_glyph;
        dp_d  = ~active_d.dp[en_d];
        if (active_d.blank[en_d]) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            en_q            <= '0;
            active_q        <= DISP_RESET;
            pending_q       <= DISP_RESET;
            pending_valid_q <= 1'b0;
            seg_q           <= SEG_HEX_0;
            dp_q            <= 1'b1;
            frame_done_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            en_q            <= en_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign en         = en_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a cycle-indexed frame model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_seg_scan_controller;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [1:0]  en;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg_scan_controller #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .en         (en),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        int         k;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: edges since reset release, shown image, last uncommitted load.
    int          k;
    logic [15:0] act_v;
    logic [3:0]  act_dp, act_bl;
    logic [15:0] pend_v;
    logic [3:0]  pend_dp, pend_bl;
    bit          pend_ok;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        act_v   = '0;
        act_dp  = '0;
        act_bl  = '0;
        pend_ok = 0;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, queue the expectation.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] b);
        exp_t e;
        int   digit;
        load     = ld;
        value_in = v;
        dp_in    = d;
        blank_in = b;
        @(posedge clk);
        k++;
        if (k % FRAME == 0) begin
            if (ld) begin
                act_v = v; act_dp = d; act_bl = b;
            end else if (pend_ok) begin
                act_v = pend_v; act_dp = pend_dp; act_bl = pend_bl;
            end
            pend_ok = 0;
        end else if (ld) begin
            pend_v = v; pend_dp = d; pend_bl = b;
            pend_ok = 1;
        end
        digit = (k / DIV) % 4;
        e.en  = 2'(digit);
        e.seg = act_bl[digit] ? 7'h7F : glyph(4'((act_v >> (4 * digit)) & 16'hF));
        e.dp  = ~act_dp[digit];
        e.fd  = (k % FRAME == 0);
        e.k   = k;
        exp_q.push_back(e);
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"}, 32'(en), 32'd0);
        chk({tag, "_seg"}, 32'(seg), 32'h40);
        chk({tag, "_dp"}, 32'(dp), 32'd1);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    task automatic apply_reset(input bit load_during);
        @(negedge clk);
        #1;
        if (load_during) begin
            load     = 1'b1;
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("en@k%0d", e.k), 32'(en), 32'(e.en));
            chk($sformatf("seg@k%0d", e.k), 32'(seg), 32'(e.seg));
            chk($sformatf("dp@k%0d", e.k), 32'(dp), 32'(e.dp));
            chk($sformatf("frame_done@k%0d", e.k), 32'(frame_done), 32'(e.fd));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        blank_in = '0;
        model_reset();
        apply_reset(0);

        // Mid-slot reset with en=2, then free-run scan and frame pulses.
        while (!(((k / DIV) % 4 == 2) && (k % DIV == 1))) idle(1);
        apply_reset(1);
        idle(3 * FRAME + 2);

        // Buffered load while en=1.
        while ((k / DIV) % 4 != 1) idle(1);
        step(1, 16'h1A2F, 4'h0, 4'h0);
        idle(2 * FRAME);

        // Last load in a frame wins.
        step(1, 16'h1111, 4'h0, 4'h0);
        idle(2);
        step(1, 16'h2222, 4'h0, 4'h0);
        idle(2 * FRAME);

        // Load coincident with the boundary.
        while ((k + 1) % FRAME != 0) idle(1);
        step(1, 16'h000E, 4'h0, 4'h0);
        idle(FRAME + 3);

        // Blank and decimal point.
        step(1, 16'h8421, 4'b0010, 4'b1000);
        idle(2 * FRAME);

        // Random loads, including coincident and back-to-back ones.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)));
            else
                idle(1);
        end

        // Reset mid-scan with a pending load discarded, then more random traffic.
        step(1, 16'hBEEF, 4'hF, 4'h0);
        apply_reset(1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0)
                step(1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                idle(1);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
